// File: rtl/clk_6p25m_monitor_if.sv
// Bundle of monitor-side signals for clk_6p25m_monitor.
// The master drives the monitored clock and the enable; the slave (the monitor) returns status.
interface clk_6p25m_monitor_if #(
    parameter int CNT_W = 16
);
    logic             mon_in;
    logic             en;
    logic [CNT_W-1:0] count_out;
    logic             count_valid;
    logic             in_range;
    logic             locked;
    logic             fault;
    logic             stuck;

    modport master (
        output mon_in, en,
        input  count_out, count_valid, in_range, locked, fault, stuck
    );

    modport slave (
        input  mon_in, en,
        output count_out, count_valid, in_range, locked, fault, stuck
    );
endinterface

// File: rtl/clk_6p25m_monitor.sv
// Frequency/lock monitor for the 6.25 MHz pixel clock, sampled in the clk domain.
// Optional no-edge (stuck) detector enabled by defining MON_STUCK_DET_EN.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_IDLE    | en=0, nothing measured, locked=0 fault=0
// ST_ACQUIRE | counting consecutive in-range windows toward lock
// ST_LOCKED  | LOCK_WINDOWS good windows seen, locked=1
// ST_FAULT   | out-of-range window (or stuck) after lock; sticky until en=0
module clk_6p25m_monitor #(
    parameter int GATE_CYCLES  = 50000,
    parameter int EXP_COUNT    = 6250,
    parameter int TOL          = 16,
    parameter int CNT_W        = 16,
    parameter int LOCK_WINDOWS = 4
) (
    input logic                 clk,
    input logic                 rst,
    clk_6p25m_monitor_if.slave  mon
);
    localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int GOOD_W = $clog2(LOCK_WINDOWS + 1);
    localparam logic [GATE_W-1:0]       GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]        CNT_MAX   = '1;
    localparam logic signed [CNT_W:0]   EXP_S     = (CNT_W+1)'(EXP_COUNT);
    localparam logic signed [CNT_W:0]   TOL_S     = (CNT_W+1)'(TOL);
    localparam logic [GOOD_W-1:0]       GOOD_LAST = GOOD_W'(LOCK_WINDOWS);

    typedef enum logic [1:0] {ST_IDLE, ST_ACQUIRE, ST_LOCKED, ST_FAULT} state_t;

    state_t              state_q, state_d;
    logic [GOOD_W-1:0]   good_q, good_d, good_inc;
    logic                sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
    logic [GATE_W-1:0]   gate_q, gate_d;
    logic [CNT_W-1:0]    edge_q, edge_d, edge_inc;
    logic [CNT_W-1:0]    count_out_q, count_out_d;
    logic                count_valid_q, count_valid_d;
    logic                in_range_q, in_range_d;
    logic                locked_q, locked_d;
    logic                fault_q, fault_d;
    logic                stuck_q, stuck_d;
    logic                rise, terminal;
    logic signed [CNT_W:0] dev, dev_abs;
`ifdef MON_STUCK_DET_EN
    localparam logic [6:0] STUCK_LIMIT = 7'd64;
    logic [6:0]          nedge_q, nedge_d;
`endif

    always_comb begin
        sync1_d  = mon.mon_in;
        sync2_d  = sync1_q;
        sync3_d  = sync2_q;
        rise     = sync2_q & ~sync3_q;
        terminal = mon.en && (gate_q == GATE_LAST);

        // The edge seen in the terminal cycle still belongs to the closing window.
        edge_inc = (rise && (edge_q != CNT_MAX)) ? edge_q + 1'b1 : edge_q;
        gate_d   = (!mon.en || terminal) ? '0 : gate_q + 1'b1;
        edge_d   = (!mon.en || terminal) ? '0 : edge_inc;

        dev     = $signed({1'b0, edge_inc}) - EXP_S;
        dev_abs = dev[CNT_W] ? -dev : dev;

        count_valid_d = terminal;
        count_out_d   = terminal ? edge_inc : count_out_q;
        in_range_d    = terminal ? (dev_abs <= TOL_S) : in_range_q;

`ifdef MON_STUCK_DET_EN
        if (!mon.en || rise)
            nedge_d = '0;
        else if (nedge_q == STUCK_LIMIT)
            nedge_d = nedge_q;
        else
            nedge_d = nedge_q + 1'b1;
        stuck_d = (nedge_d == STUCK_LIMIT);
`else
        stuck_d = 1'b0;
`endif

        state_d  = state_q;
        good_d   = good_q;
        good_inc = good_q + 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (mon.en) begin
                    state_d = ST_ACQUIRE;
                    good_d  = '0;
                end
            end
            ST_ACQUIRE: begin
                if (count_valid_q) begin
                    if (in_range_q) begin
                        good_d = good_inc;
                        if (good_inc == GOOD_LAST)
                            state_d = ST_LOCKED;
                    end else begin
                        good_d = '0;
                    end
                end
            end
            ST_LOCKED: begin
                if (count_valid_q && !in_range_q)
                    state_d = ST_FAULT;
            end
            default: state_d = state_q;
        endcase

        if (stuck_d && ((state_q == ST_ACQUIRE) || (state_q == ST_LOCKED)))
            state_d = ST_FAULT;

        // Dropping en abandons any partial window and wins over every other event.
        if (!mon.en) begin
            state_d = ST_IDLE;
            good_d  = '0;
        end

        locked_d = (state_d == ST_LOCKED);
        fault_d  = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            good_q        <= '0;
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            sync3_q       <= 1'b0;
            gate_q        <= '0;
            edge_q        <= '0;
            count_out_q   <= '0;
            count_valid_q <= 1'b0;
            in_range_q    <= 1'b0;
            locked_q      <= 1'b0;
            fault_q       <= 1'b0;
            stuck_q       <= 1'b0;
`ifdef MON_STUCK_DET_EN
            nedge_q       <= '0;
`endif
        end else begin
            state_q       <= state_d;
            good_q        <= good_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            sync3_q       <= sync3_d;
            gate_q        <= gate_d;
            edge_q        <= edge_d;
            count_out_q   <= count_out_d;
            count_valid_q <= count_valid_d;
            in_range_q    <= in_range_d;
            locked_q      <= locked_d;
            fault_q       <= fault_d;
            stuck_q       <= stuck_d;
`ifdef MON_STUCK_DET_EN
            nedge_q       <= nedge_d;
`endif
        end
    end

    assign mon.count_out   = count_out_q;
    assign mon.count_valid = count_valid_q;
    assign mon.in_range    = in_range_q;
    assign mon.locked      = locked_q;
    assign mon.fault       = fault_q;
    assign mon.stuck       = stuck_q;
endmodule

// File: doc/clk_6p25m_monitor.md
Name: clk_6p25m_monitor

Overview:
Frequency and lock monitor for the 6.25 MHz pixel clock produced by the PLL clock generator. It runs in the system clock domain and samples the generated clock as a data signal. It counts rising edges over a fixed gate window and compares each count against an expected value. It reports per-window counts, an in-range flag, and a lock/fault status used by the display reset and bring-up logic.

Parameters:
GATE_CYCLES, 50000, gate window length in clk cycles (1 ms at 50 MHz)
EXP_COUNT, 6250, expected rising edges per window
TOL, 16, allowed absolute deviation from EXP_COUNT (inclusive)
CNT_W, 16, width of edge counter and count_out
LOCK_WINDOWS, 4, consecutive in-range windows required to declare lock

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
mon_in  input  1  monitored clock, asynchronous to clk; must be < clk/2
en  input  1  monitor enable
count_out  output  CNT_W  edge count of the last completed window
count_valid  output  1  one-cycle pulse when count_out updates
in_range  output  1  |count_out - EXP_COUNT| <= TOL for the last window
locked  output  1  FSM in LOCKED
fault  output  1  FSM in FAULT (sticky)
stuck  output  1  stuck-at detect flag (see Optional Feature)

Behaviour:
- Reset: all outputs 0; synchronizer flops, counters and FSM cleared; FSM = IDLE.
- Input path: 2-flop synchronizer, then a third flop for edge detect. rise = sync2 & ~sync3. A mon_in edge reaches the edge counter 3 clk cycles later.
- Gate counter: counts 0..GATE_CYCLES-1 while en=1, then wraps to 0. It is held at 0 while en=0. The first window starts the cycle after en rises.
- Edge counter: increments on rise and saturates at 2^CNT_W-1. In the terminal gate cycle:
  - count_out <= edge count, including a rise occurring in that same cycle.
  - The edge counter restarts at 0.
  - count_valid pulses for 1 cycle.
  - in_range updates in the same cycle as count_out.
- Arithmetic: deviation is computed at CNT_W+1 bits signed; there is no wrap.
- FSM:
  - IDLE: locked=0, fault=0. en=1 -> ACQUIRE with good_cnt=0.
  - ACQUIRE: on count_valid:
    - in_range -> good_cnt+1; reaching LOCK_WINDOWS -> LOCKED.
    - not in_range -> good_cnt=0.
  - LOCKED: locked=1. count_valid & ~in_range -> FAULT.
  - FAULT: fault=1, locked=0. Held until en=0 or rst.
  - Any state, en=0 -> IDLE next cycle:
    - gate and edge counters cleared;
    - partial window discarded (no count_valid);
    - count_out and in_range retain their last value.
- Simultaneous events: en falling in the terminal gate cycle means the window is discarded (en=0 has priority). rst has priority over everything.
- locked/fault transition in the cycle after the count_valid that causes them. Outputs are registered.

Optional Feature:
MON_STUCK_DET_EN
- Defined:
  - A no-edge timer is cleared on every rise and increments otherwise while en=1.
  - When it reaches 64, stuck=1 and the FSM goes from ACQUIRE/LOCKED to FAULT in the same update.
  - stuck clears on the next rise, or when en=0, or on rst. fault stays sticky.
- Undefined: stuck is tied to 0, no timer logic is present, and FSM behaviour is unchanged otherwise.

Test Plan:
(bench params: GATE_CYCLES=800, EXP_COUNT=100, TOL=2, LOCK_WINDOWS=4)
1. Reset: rst=1 for 3 cycles with mon_in toggling -> all outputs 0; no count_valid while en=0.
2. mon_in period 8 clk, en=1 -> count_valid every 800 cycles with count_out=100 (±1 at first window), in_range=1; locked=1 the cycle after the 4th count_valid.
3. Locked, then period switched to 10 clk -> next full window count_out=80, in_range=0; fault=1, locked=0 the next cycle; stays in FAULT for 5 further windows; en=0 -> fault=0.
4. Period 9 (count ~88) for 6 windows -> locked stays 0. Then period 8 -> locked only after 4 consecutive good windows. Insert a bad window after 2 good ones and confirm good_cnt restarts.
5. en dropped at gate cycle 400 and again exactly at cycle 799 -> no count_valid either time; count_out keeps its prior value; FSM = IDLE next cycle.
6. MON_STUCK_DET_EN defined, locked, mon_in held 0 -> stuck=1 and fault=1 at the 64th cycle after the last rise. Undefined, same stimulus -> stuck=0, and fault only at window end (count 0 out of range).
